// File: rtl/hps_reset_sequencer_if.sv
// Request/pulse bundle between the FPGA-side reset request logic and hps_reset_sequencer.
// The evt_cnt signal exists only when HPS_RSTSEQ_CNT_EN is defined.
interface hps_reset_sequencer_if;
    logic       cold_req_in;
    logic       warm_req_in;
    logic       dbg_req_in;
    logic       hps_cold_reset;
    logic       hps_warm_reset;
    logic       hps_dbg_reset;
    logic       busy;
    logic [1:0] last_src;
`ifdef HPS_RSTSEQ_CNT_EN
    logic [7:0] evt_cnt;

    modport master (
        output cold_req_in, warm_req_in, dbg_req_in,
        input  hps_cold_reset, hps_warm_reset, hps_dbg_reset, busy, last_src, evt_cnt
    );
    modport slave (
        input  cold_req_in, warm_req_in, dbg_req_in,
        output hps_cold_reset, hps_warm_reset, hps_dbg_reset, busy, last_src, evt_cnt
    );
`else
    modport master (
        output cold_req_in, warm_req_in, dbg_req_in,
        input  hps_cold_reset, hps_warm_reset, hps_dbg_reset, busy, last_src
    );
    modport slave (
        input  cold_req_in, warm_req_in, dbg_req_in,
        output hps_cold_reset, hps_warm_reset, hps_dbg_reset, busy, last_src
    );
`endif
endinterface

// File: rtl/hps_reset_sequencer.sv
// Edge-triggered, fixed-priority reset pulse sequencer for the HPS cold/warm/debug reset inputs.
// Define HPS_RSTSEQ_CNT_EN to add the saturating grant counter evt_cnt.
module hps_reset_sequencer #(
    parameter int unsigned PULSE_EXT             = 6,
    parameter int unsigned HOLDOFF               = 16,
    parameter int unsigned EDGE_TYPE             = 1,
    parameter int unsigned IGNORE_RST_WHILE_BUSY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    hps_reset_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_HOLDOFF} state_e;
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_COLD = 2'd1,
        SRC_WARM = 2'd2,
        SRC_DBG  = 2'd3
    } src_e;

    localparam logic [7:0] PULSE_LOAD   = 8'(PULSE_EXT - 1);
    localparam logic [7:0] HOLD_LOAD    = (HOLDOFF == 0) ? 8'd0 : 8'(HOLDOFF - 1);
    localparam bit         KEEP_PENDING = (IGNORE_RST_WHILE_BUSY == 0);

    logic [2:0] req;        // bit 0 cold, bit 1 warm, bit 2 debug
    logic [2:0] req_dly_q;
    logic [2:0] edge_det;
    logic [2:0] pend_set;
    logic [2:0] pend_q;
    logic [2:0] pend_d;
    logic [2:0] rst_out_q;
    logic [7:0] cnt_q;
    logic       busy_q;
    logic       preempt;
    logic       busy_exit;
    state_e     state_q;
    src_e       src_q;
    src_e       last_src_q;
    src_e       grant_src;

    function automatic src_e pick_src(input logic [2:0] v);
        if (v[0]) return SRC_COLD;
        if (v[1]) return SRC_WARM;
        if (v[2]) return SRC_DBG;
        return SRC_NONE;
    endfunction

    function automatic logic [2:0] src_mask(input src_e s);
        case (s)
            SRC_COLD: return 3'b001;
            SRC_WARM: return 3'b010;
            SRC_DBG:  return 3'b100;
            default:  return 3'b000;
        endcase
    endfunction

    assign req      = {bus.dbg_req_in, bus.warm_req_in, bus.cold_req_in};
    assign edge_det = (EDGE_TYPE != 0) ? (req & ~req_dly_q) : (~req & req_dly_q);
    assign pend_set = KEEP_PENDING ? edge_det : 3'b000;

    // A cold edge cuts a warm/debug pulse short whatever the busy policy is.
    assign preempt   = (state_q == S_PULSE) && edge_det[0] && (src_q != SRC_COLD);
    // Last busy cycle: the next pulse may be granted here so no idle gap appears.
    assign busy_exit = (cnt_q == 8'd0) &&
                       (((state_q == S_PULSE) && (HOLDOFF == 0)) || (state_q == S_HOLDOFF));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant_src = SRC_NONE;
        if (state_q == S_IDLE) begin
            grant_src = pick_src(edge_det | pend_q);
        end else if (preempt) begin
            grant_src = SRC_COLD;
        end else if (busy_exit) begin
            grant_src = pick_src(pend_q | pend_set);
        end
    end

    assign pend_d = (pend_q | pend_set) & ~src_mask(grant_src);

    // NOTE: sequential state uses non-blocking assignments only, so every register sees
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_dly_q  <= req;
            pend_q     <= 3'b000;
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            src_q      <= SRC_NONE;
            last_src_q <= SRC_NONE;
            rst_out_q  <= 3'b000;
            busy_q     <= 1'b0;
        end else begin
            req_dly_q <= req;
            pend_q    <= pend_d;
            if (grant_src != SRC_NONE) begin
                state_q    <= S_PULSE;
                cnt_q      <= PULSE_LOAD;
                src_q      <= grant_src;
                last_src_q <= grant_src;
                rst_out_q  <= src_mask(grant_src);
                busy_q     <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: ;
                    S_PULSE: begin
                        if (cnt_q == 8'd0) begin
                            rst_out_q <= 3'b000;
                            src_q     <= SRC_NONE;
                            if (HOLDOFF == 0) begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= S_HOLDOFF;
                                cnt_q   <= HOLD_LOAD;
                            end
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                    S_HOLDOFF: begin
                        if (cnt_q == 8'd0) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                    default: begin
                        state_q   <= S_IDLE;
                        cnt_q     <= 8'd0;
                        src_q     <= SRC_NONE;
                        rst_out_q <= 3'b000;
                        busy_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.hps_cold_reset = rst_out_q[0];
    assign bus.hps_warm_reset = rst_out_q[1];
    assign bus.hps_dbg_reset  = rst_out_q[2];
    assign bus.busy           = busy_q;
    assign bus.last_src       = last_src_q;

`ifdef HPS_RSTSEQ_CNT_EN
    logic [7:0] evt_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            evt_cnt_q <= 8'd0;
        end else if ((grant_src != SRC_NONE) && (evt_cnt_q != 8'hFF)) begin
            evt_cnt_q <= evt_cnt_q + 8'd1;
        end
    end

    assign bus.evt_cnt = evt_cnt_q;
`endif

endmodule
